// File: rtl/if_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_stage_if                                                      |
// | Purpose : Bus bundle for the instruction-fetch stage. It carries the       |
// |           instruction-memory request/grant/response channel and the        |
// |           instruction hand-off (valid/ready) to decode.                    |
// | Ports   : master - the fetch stage (drives imem_req/addr, inst_*)          |
// |           slave  - memory + consumer side (drives gnt/rvalid/rdata/ready)  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_stage                                                         |
// | Purpose : RV32I instruction fetch. Owns the fetch PC, issues word fetches, |
// |           pairs responses with their addresses and buffers them in a      |
// |           2-entry FIFO towards decode. Redirects flush the FIFO and drop   |
// |           responses still in flight.                                       |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           bus           - if_stage_if.master (imem channel + inst hand-off)|
// |           redirect_i    - taken jump/branch pulse                          |
// |           redirect_pc_i - new fetch target (low 2 bits ignored)            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        bus,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i
);

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  discard_q, discard_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        pcq_rd_q, pcq_wr_q;
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] pcq_q       [2];
  logic [31:0] hold_inst_q, hold_pc_q;

  logic        w_valid, w_pop, w_req, w_grant, w_rvalid, w_drop, w_push;
  logic [2:0]  w_level;

  assign w_valid  = (count_q != 2'd0);
  assign w_pop    = w_valid && bus.inst_ready;
  // Credits: in-flight requests plus buffered words must never exceed the
  // FIFO depth, counting a pop this cycle as already freed.
  assign w_level  = {1'b0, outst_q} + {1'b0, count_q} - {2'b00, w_pop};
  // rst_n gates the request so it drops at once on an asynchronous reset.
  assign w_req    = rst_n && !redirect_i && (w_level < 3'd2);
  assign w_grant  = w_req && bus.imem_gnt;
  assign w_rvalid = bus.imem_rvalid;
  assign w_drop   = w_rvalid && (discard_q != 2'd0);
  assign w_push   = w_rvalid && !w_drop && !redirect_i;

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = w_valid;
  // While empty, show the last presented word rather than stale slot data.
  assign bus.inst       = w_valid ? fifo_inst_q[rd_ptr_q] : hold_inst_q;
  assign bus.inst_pc    = w_valid ? fifo_pc_q[rd_ptr_q]   : hold_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + {1'b0, w_grant} - {1'b0, w_rvalid};
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      // Everything still in flight after this cycle belongs to the old stream;
      // a response landing this cycle is dropped by not pushing it.
      discard_d  = outst_q - {1'b0, w_rvalid};
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (w_grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (w_drop)  discard_d  = discard_q - 2'd1;
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop)  rd_ptr_d = ~rd_ptr_q;
      if (w_push) wr_ptr_d = ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      outst_q     <= 2'd0;
      discard_q   <= 2'd0;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pcq_rd_q    <= 1'b0;
      pcq_wr_q    <= 1'b0;
      hold_inst_q <= c_NOP;
      hold_pc_q   <= RESET_PC;
      for (int i = 0; i < 2; i++) begin
        fifo_inst_q[i] <= c_NOP;
        fifo_pc_q[i]   <= RESET_PC;
        pcq_q[i]       <= RESET_PC;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      // The pc queue tracks every granted request, including ones later
      // discarded, so it stays aligned with the in-order response stream.
      if (w_grant) begin
        pcq_q[pcq_wr_q] <= fetch_pc_q;
        pcq_wr_q        <= ~pcq_wr_q;
      end
      if (w_rvalid) pcq_rd_q <= ~pcq_rd_q;
      if (w_push) begin
        fifo_inst_q[wr_ptr_q] <= bus.imem_rdata;
        fifo_pc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
      end
      if (w_valid) begin
        hold_inst_q <= fifo_inst_q[rd_ptr_q];
        hold_pc_q   <= fifo_pc_q[rd_ptr_q];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_if_stage                                                      |
// | Purpose : Directed self-checking bench for if_stage with an in-order       |
// |           fixed-latency instruction memory whose word at address A is ~A. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_if_stage;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;

  if_stage_if bus ();

  if_stage #(.RESET_PC(c_RESET_PC)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          k;
  int          n_pop;
  logic [31:0] exp_pc;
  logic [31:0] rq_addr [$];
  int          rq_due  [$];
  logic [31:0] req_log [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle, entered and left at a falling edge. Presents a due
  // response, records grants, and checks every word decode pops.
  task automatic step();
    bit resp;
    resp = (rq_addr.size() > 0) && (rq_due[0] <= cyc);
    bus.imem_rvalid = resp;
    bus.imem_rdata  = resp ? ~rq_addr[0] : 32'h0;
    #1;
    if (bus.imem_req && bus.imem_gnt) begin
      rq_addr.push_back(bus.imem_addr);
      rq_due.push_back(cyc + k);
      req_log.push_back(bus.imem_addr);
    end
    if (bus.inst_valid && bus.inst_ready && !redirect) begin
      check("pop_pc", bus.inst_pc, exp_pc);
      check("pop_inst", bus.inst, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    @(posedge clk);
    cyc++;
    if (resp) begin
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    rq_addr.delete();
    rq_due.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cyc    = 0;
    n_pop  = 0;
    exp_pc = c_RESET_PC;
    req_log.delete();
  endtask

  task automatic start_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    exp_pc      = {target[31:2], 2'b00};
    n_pop       = 0;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    bus.imem_gnt   = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b1;
    k              = 1;
    cyc            = 0;
    n_pop          = 0;
    exp_pc         = c_RESET_PC;

    // Reset values and start-up streaming
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, c_RESET_PC);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'h0000_0013);
    check("rst_pc", bus.inst_pc, c_RESET_PC);
    do_reset();
    step();
    check("t1_nreq_c1", req_log.size(), 32'd1);
    check("t1_valid_c1", {31'b0, bus.inst_valid}, 32'd0);
    step();
    check("t1_valid_c2", {31'b0, bus.inst_valid}, 32'd1);
    check("t1_pc_c2", bus.inst_pc, 32'h100);
    repeat (6) step();
    check("t1_req0", log_at(0), 32'h100);
    check("t1_req1", log_at(1), 32'h104);
    check("t1_req2", log_at(2), 32'h108);
    check("t1_nreq", req_log.size(), 32'd8);
    check("t1_npop", n_pop, 32'd6);

    // Backpressure
    do_reset();
    bus.inst_ready = 1'b0;
    repeat (10) step();
    check("t2_nreq", req_log.size(), 32'd2);
    check("t2_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("t2_head", bus.inst_pc, 32'h100);
    check("t2_req_off", {31'b0, bus.imem_req}, 32'd0);
    bus.inst_ready = 1'b1;
    repeat (6) step();
    check("t2_npop", n_pop, 32'd6);
    check("t2_req2", log_at(2), 32'h108);

    // Redirect with two responses in flight (k = 3)
    do_reset();
    k = 3;
    repeat (3) step();
    check("t3_nreq", req_log.size(), 32'd2);
    start_redirect(32'h2002);
    check("t3_valid_r1", {31'b0, bus.inst_valid}, 32'd0);
    check("t3_addr_r1", bus.imem_addr, 32'h2000);
    step();
    check("t3_valid_r2", {31'b0, bus.inst_valid}, 32'd0);
    repeat (5) step();
    check("t3_req2", log_at(2), 32'h2000);
    check("t3_npop", n_pop, 32'd2);

    // Back-to-back redirects while discard is nonzero
    do_reset();
    k = 3;
    step();
    start_redirect(32'h400);
    step();
    start_redirect(32'h800);
    repeat (8) step();
    check("t4_req1", log_at(1), 32'h400);
    check("t4_req2", log_at(2), 32'h800);
    check("t4_popped", {31'b0, n_pop > 0}, 32'd1);

    // Address wrap-around
    do_reset();
    k = 1;
    repeat (2) step();
    req_log.delete();
    start_redirect(32'hFFFF_FFF8);
    repeat (6) step();
    check("t5_req0", log_at(0), 32'hFFFF_FFF8);
    check("t5_req1", log_at(1), 32'hFFFF_FFFC);
    check("t5_req2", log_at(2), 32'h0000_0000);
    check("t5_npop", n_pop, 32'd4);

    // Asynchronous reset with a full FIFO
    do_reset();
    k = 1;
    bus.inst_ready = 1'b0;
    repeat (4) step();
    bus.inst_ready = 1'b1;
    #1;
    check("t6_pre_req", {31'b0, bus.imem_req}, 32'd1);
    check("t6_pre_valid", {31'b0, bus.inst_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("t6_async_req", {31'b0, bus.imem_req}, 32'd0);
    do_reset();
    repeat (4) step();
    check("t6_req0", log_at(0), c_RESET_PC);
    check("t6_npop", n_pop, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32I core. It owns the fetch PC, issues word requests to instruction memory over a request/grant and response-valid interface, and buffers returned words in a 2-entry FIFO. It presents the words to the control unit and decode as `inst`/`inst_pc` under a valid/ready handshake. Execute redirects it on taken jumps and branches (`pcsel` = ALU); responses still in flight at redirect time are dropped.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address; bits [1:0] always 0.
- `imem_gnt`  in  1  request accepted this cycle (`imem_req && imem_gnt`).
- `imem_rvalid`  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- `imem_rdata`  in  32  response instruction word.
- `inst_valid`  out  1  FIFO head valid.
- `inst`  out  32  FIFO head instruction.
- `inst_pc`  out  32  address of `inst`.
- `inst_ready`  in  1  consumer pops the head when `inst_valid && inst_ready`.
- `redirect`  in  1  taken jump or branch, one-cycle pulse.
- `redirect_pc`  in  32  new fetch target; bits [1:0] forced to 0.

## Operation
- State:
  - `fetch_pc` (32b).
  - `outstanding` (0..2): granted requests without a response.
  - `discard` (0..2): in-flight responses to drop.
  - FIFO of depth 2; each entry holds {inst, pc}.
  - A 2-entry pc queue pairs each response with its request address.
- Credit rule:
  - `imem_req` = `!redirect && (outstanding + occupancy - pop) < 2`.
  - Pop is `inst_valid && inst_ready`. This is a combinational path from `inst_ready`, and it is allowed.
- On grant: `fetch_pc += 4` with 32-bit wrap (0xFFFF_FFFC → 0x0000_0000); `outstanding++`.
- On `imem_rvalid`:
  - `outstanding--`.
  - If `discard > 0`: decrement `discard` and drop the word.
  - Otherwise push {imem_rdata, queued pc} into the FIFO. The credit rule guarantees the FIFO is never full here.
- Grant and rvalid in the same cycle: net `outstanding` change is 0.
- Push and pop in the same cycle: occupancy unchanged; head advances.
- Redirect:
  - The FIFO is flushed.
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - `discard <= outstanding - (imem_rvalid ? 1 : 0)`. A response arriving in the redirect cycle is itself dropped.
  - `imem_req` is 0 in the redirect cycle, so no request is granted then.
  - Redirect overrides any simultaneous pop or push.
- Redirect while `discard > 0`: the formula above applies unchanged, because `outstanding` already counts every in-flight request.
- `inst`/`inst_pc` hold their last value while `inst_valid = 0`.

## Timing
- Reset values: `imem_req = 0` while `rst_n = 0`; `imem_addr = RESET_PC`; `inst_valid = 0`; `inst = 32'h0000_0013` (NOP); `inst_pc = RESET_PC`; all counters 0; FIFO empty.
- First cycle after reset release: `imem_req = 1`, `imem_addr = RESET_PC`.
- Latency: grant at cycle t, rvalid at t+k (k ≥ 1), `inst_valid` at t+k+1. The FIFO is registered; there is no bypass.
- With k = 1 and `inst_ready` held at 1, throughput is 1 instruction per cycle after a 2-cycle fill.
- Redirect at cycle r:
  - First request to the new target at r+1.
  - The earliest new instruction is visible at r+3.
  - `inst_valid = 0` from r+1 until that instruction is visible.
- `rst_n` asserted mid-operation: all state clears immediately. Responses arriving after reset release while `outstanding = 0` are a memory protocol error and are not supported.

## Test plan
- **Reset and start:** RESET_PC = 0x100, k = 1, `inst_ready = 1`. Requests go to 0x100, 0x104, 0x108. `inst_pc` shows 0x100 at cycle 3, then +4 every cycle. `inst` matches memory contents.
- **Backpressure:** `inst_ready = 0` for 10 cycles. Exactly 2 requests are granted, FIFO holds 0x100/0x104, and `imem_req = 0`. After release, pops continue in order with no loss and no duplicates.
- **Redirect with flight:** k = 3, 2 requests outstanding, redirect to 0x2002. Both stale responses are dropped, including one arriving in the redirect cycle. The next request address is 0x2000, and the first valid `inst_pc` is 0x2000.
- **Back-to-back redirects:** redirect to 0x400, then redirect to 0x800 two cycles later while `discard` is nonzero. No 0x400-stream word ever reaches `inst_valid`; the first valid `inst_pc` is 0x800.
- **Wrap-around:** redirect to 0xFFFF_FFF8. Request addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Async reset mid-fetch:** drop `rst_n` between clock edges with a full FIFO. `inst_valid` and `imem_req` go to 0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
